// File: rtl/sram_arbiter.sv
// Two-port arbiter for one 16-bit async SRAM: each 32-bit word is a low-half then high-half access,
// and partial-halfword writes are done as read-modify-write because the SRAM has no byte lanes.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_we,
  input  logic [16:0] req_addr0,
  input  logic [16:0] req_addr1,
  input  logic [31:0] req_wdata0,
  input  logic [31:0] req_wdata1,
  input  logic [3:0]  req_wstrb0,
  input  logic [3:0]  req_wstrb1,
  output logic [1:0]  req_ready,
  output logic [31:0] req_rdata,
  output logic        grant,
  output logic        busy,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_d_out,
  output logic        sram_d_oe,
  input  logic [15:0] sram_d_in,
  output logic        sram_cs_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(ACCESS_CYCLES - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_TA, ST_WR, ST_REC, ST_DONE} state_t;

  state_t        state_reg, state_next;
  logic          grant_reg, grant_next;
  logic          we_reg, we_next;
  logic [16:0]   addr_reg, addr_next;
  logic [31:0]   wdata_reg, wdata_next;
  logic [3:0]    wstrb_reg, wstrb_next;
  logic          half_reg, half_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [15:0]   rd_buf_reg, rd_buf_next;
  logic [31:0]   rdata_reg, rdata_next;
  logic [15:0]   d_out_reg, d_out_next;
  logic          cs_n_reg, cs_n_next;
  logic          oe_n_reg, oe_n_next;
  logic          we_n_reg, we_n_next;
  logic          d_oe_reg, d_oe_next;

  logic          sel_port, sel_we;
  logic [16:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic [3:0]    sel_wstrb;
  logic [1:0]    cur_s;
  logic [15:0]   cur_w;
  logic          half_done, launch, launch_half, launch_we;
  logic [1:0]    launch_s;
  logic [15:0]   launch_w;

  function automatic logic [15:0] merge_half(input logic [15:0] w, input logic [15:0] r,
                                             input logic [1:0] s);
    return {s[1] ? w[15:8] : r[15:8], s[0] ? w[7:0] : r[7:0]};
  endfunction

  // Round-robin pick: on contention the port that was not served last wins.
  always_comb begin
    sel_port  = (req_valid == 2'b11) ? ~grant_reg : req_valid[1];
    sel_we    = req_we[sel_port];
    sel_addr  = sel_port ? req_addr1  : req_addr0;
    sel_wdata = sel_port ? req_wdata1 : req_wdata0;
    sel_wstrb = sel_port ? req_wstrb1 : req_wstrb0;
  end

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    we_next     = we_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    wstrb_next  = wstrb_reg;
    half_next   = half_reg;
    cnt_next    = cnt_reg;
    rd_buf_next = rd_buf_reg;
    rdata_next  = rdata_reg;
    d_out_next  = d_out_reg;
    cur_s       = half_reg ? wstrb_reg[3:2] : wstrb_reg[1:0];
    cur_w       = half_reg ? wdata_reg[31:16] : wdata_reg[15:0];
    half_done   = 1'b0;
    launch      = 1'b0;
    launch_half = 1'b0;
    launch_we   = we_reg;
    launch_s    = 2'b00;
    launch_w    = 16'h0000;

    case (state_reg)
      ST_IDLE: begin
        if (|req_valid) begin
          grant_next = sel_port;
          we_next    = sel_we;
          addr_next  = sel_addr;
          wdata_next = sel_wdata;
          wstrb_next = sel_wstrb;
          launch_we  = sel_we;
          if (!sel_we || sel_wstrb[1:0] != 2'b00) begin
            launch   = 1'b1;
            launch_s = sel_wstrb[1:0];
            launch_w = sel_wdata[15:0];
          end else if (sel_wstrb[3:2] != 2'b00) begin
            launch      = 1'b1;
            launch_half = 1'b1;
            launch_s    = sel_wstrb[3:2];
            launch_w    = sel_wdata[31:16];
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_RD: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CW'(1);
        end else begin
          rd_buf_next = sram_d_in;
          if (we_reg) begin
            state_next = ST_TA;
          end else begin
            if (half_reg) rdata_next = {sram_d_in, rd_buf_reg};
            half_done = 1'b1;
          end
        end
      end
      ST_TA: begin
        state_next = ST_WR;
        cnt_next   = CNT_LOAD;
        d_out_next = merge_half(cur_w, rd_buf_reg, cur_s);
      end
      ST_WR: begin
        if (cnt_reg != '0) cnt_next = cnt_reg - CW'(1);
        else               state_next = ST_REC;
      end
      ST_REC:  half_done  = 1'b1;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase

    // A high half with no strobes on a write is skipped entirely.
    if (half_done) begin
      if (!half_reg && (!we_reg || wstrb_reg[3:2] != 2'b00)) begin
        launch      = 1'b1;
        launch_half = 1'b1;
        launch_s    = wstrb_reg[3:2];
        launch_w    = wdata_reg[31:16];
      end else begin
        state_next = ST_DONE;
      end
    end

    if (launch) begin
      half_next = launch_half;
      cnt_next  = CNT_LOAD;
      if (launch_we && launch_s == 2'b11) begin
        state_next = ST_WR;
        d_out_next = launch_w;
      end else begin
        state_next = ST_RD;
      end
    end

    cs_n_next = !(state_next == ST_RD || state_next == ST_TA ||
                  state_next == ST_WR || state_next == ST_REC);
    oe_n_next = (state_next != ST_RD);
    we_n_next = (state_next != ST_WR);
    d_oe_next = (state_next == ST_WR || state_next == ST_REC);
  end

  // Strobes are registered from the next state so the pads never see decode glitches.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= ST_IDLE;
      grant_reg  <= 1'b1;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      wstrb_reg  <= '0;
      half_reg   <= 1'b0;
      cnt_reg    <= '0;
      rd_buf_reg <= '0;
      rdata_reg  <= '0;
      d_out_reg  <= '0;
      cs_n_reg   <= 1'b1;
      oe_n_reg   <= 1'b1;
      we_n_reg   <= 1'b1;
      d_oe_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      we_reg     <= we_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      wstrb_reg  <= wstrb_next;
      half_reg   <= half_next;
      cnt_reg    <= cnt_next;
      rd_buf_reg <= rd_buf_next;
      rdata_reg  <= rdata_next;
      d_out_reg  <= d_out_next;
      cs_n_reg   <= cs_n_next;
      oe_n_reg   <= oe_n_next;
      we_n_reg   <= we_n_next;
      d_oe_reg   <= d_oe_next;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign req_ready[gi] = (state_reg == ST_DONE) && (grant_reg == 1'(gi));
  end

  assign req_rdata  = rdata_reg;
  assign grant      = grant_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign sram_addr  = {addr_reg, half_reg};
  assign sram_d_out = d_out_reg;
  assign sram_d_oe  = d_oe_reg;
  assign sram_cs_n  = cs_n_reg;
  assign sram_oe_n  = oe_n_reg;
  assign sram_we_n  = we_n_reg;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed cases plus random two-port traffic against a word-level
// reference memory, with an SRAM pad model and strobe-protocol monitor.
module tb_sram_arbiter;
  localparam int AC = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  req_valid, req_we, req_ready;
  logic [16:0] req_addr0, req_addr1;
  logic [31:0] req_wdata0, req_wdata1, req_rdata;
  logic [3:0]  req_wstrb0, req_wstrb1;
  logic        grant, busy, sram_d_oe, sram_cs_n, sram_oe_n, sram_we_n;
  logic [17:0] sram_addr;
  logic [15:0] sram_d_out, sram_d_in;

  logic [15:0] sram_mem [0:63];
  logic [15:0] ref_mem  [0:63];
  int          vectors = 0, miscompares = 0;
  int          oe_cnt = 0, we_cnt = 0, cs_cnt = 0, viol = 0;
  logic        grant_m;
  logic [31:0] rdata_m;
  logic        prev_wr = 1'b0;
  logic [17:0] prev_addr = '0;
  logic [15:0] prev_dout = '0;

  sram_arbiter #(.ACCESS_CYCLES(AC)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_we(req_we),
    .req_addr0(req_addr0), .req_addr1(req_addr1), .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_wstrb0(req_wstrb0), .req_wstrb1(req_wstrb1), .req_ready(req_ready), .req_rdata(req_rdata),
    .grant(grant), .busy(busy), .sram_addr(sram_addr), .sram_d_out(sram_d_out),
    .sram_d_oe(sram_d_oe), .sram_d_in(sram_d_in), .sram_cs_n(sram_cs_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  assign sram_d_in = (!sram_cs_n && !sram_oe_n) ? sram_mem[sram_addr[5:0]] : 16'h0000;

  // SRAM model and pad-protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!sram_cs_n) cs_cnt++;
    if (!sram_oe_n) oe_cnt++;
    if (!sram_we_n) we_cnt++;
    if (!sram_oe_n && !sram_we_n) viol++;
    if (sram_d_oe && !sram_oe_n) viol++;
    if (!sram_we_n && (!sram_d_oe || sram_cs_n)) viol++;
    if ((!sram_oe_n || !sram_we_n) && sram_cs_n) viol++;
    if (!sram_cs_n && sram_addr[17:6] != 12'd0) viol++;
    if (prev_wr && !sram_cs_n && (sram_addr != prev_addr || sram_d_out != prev_dout)) viol++;
    if (!sram_cs_n && !sram_we_n) sram_mem[sram_addr[5:0]] = sram_d_out;
    prev_wr   = !sram_cs_n && !sram_we_n;
    prev_addr = sram_addr;
    prev_dout = sram_d_out;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int half_cs(input logic [1:0] hs);
    if (hs == 2'b00) return 0;
    if (hs == 2'b11) return AC + 1;
    return 2 * AC + 2;
  endfunction

  function automatic int exp_lat(input logic we, input logic [3:0] s);
    if (!we) return 2 * AC + 1;
    return 1 + half_cs(s[1:0]) + half_cs(s[3:2]);
  endfunction

  function automatic int exp_cs(input logic we, input logic [3:0] s);
    if (!we) return 2 * AC;
    return half_cs(s[1:0]) + half_cs(s[3:2]);
  endfunction

  function automatic int exp_oe(input logic we, input logic [3:0] s);
    if (!we) return 2 * AC;
    return ((^s[1:0]) ? AC : 0) + ((^s[3:2]) ? AC : 0);
  endfunction

  function automatic int exp_we(input logic we, input logic [3:0] s);
    if (!we) return 0;
    return ((s[1:0] != 2'b00) ? AC : 0) + ((s[3:2] != 2'b00) ? AC : 0);
  endfunction

  // Word-level reference: returns the word as read (reads) or as stored after byte merge (writes).
  function automatic logic [31:0] ref_apply(input logic we, input logic [16:0] a,
                                            input logic [31:0] d, input logic [3:0] s);
    logic [5:0]  lo_i;
    logic [31:0] w;
    lo_i = {a[4:0], 1'b0};
    w = {ref_mem[lo_i + 6'd1], ref_mem[lo_i]};
    if (we) begin
      for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
      ref_mem[lo_i]        = w[15:0];
      ref_mem[lo_i + 6'd1] = w[31:16];
    end
    return w;
  endfunction

  // Issue one or two requests at once (called at posedge+1 with the arbiter idle).
  task automatic run_txns(input logic [1:0] mask, input logic [1:0] we,
                          input logic [16:0] a0, input logic [16:0] a1,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [3:0] s0, input logic [3:0] s1);
    int          order [2];
    logic [16:0] a [2];
    logic [31:0] d [2];
    logic [3:0]  s [2];
    logic [31:0] w;
    int          n, served, due, p, k, oe0, we0, cs0, oe_e, we_e, cs_e;
    a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1; s[0] = s0; s[1] = s1;
    n = (mask == 2'b11) ? 2 : 1;
    order[0] = (mask == 2'b11) ? (grant_m ? 0 : 1) : (mask[1] ? 1 : 0);
    order[1] = 1 - order[0];
    oe_e = 0; we_e = 0; cs_e = 0;
    for (int i = 0; i < n; i++) begin
      oe_e += exp_oe(we[order[i]], s[order[i]]);
      we_e += exp_we(we[order[i]], s[order[i]]);
      cs_e += exp_cs(we[order[i]], s[order[i]]);
    end
    oe0 = oe_cnt; we0 = we_cnt; cs0 = cs_cnt;
    req_we = we; req_addr0 = a0; req_addr1 = a1; req_wdata0 = d0; req_wdata1 = d1;
    req_wstrb0 = s0; req_wstrb1 = s1; req_valid = mask;
    served = 0;
    due = exp_lat(we[order[0]], s[order[0]]);
    for (k = 1; k <= 200 && served < n; k++) begin
      @(posedge clk); #1;
      if (req_ready != 2'b00) begin
        p = order[served];
        check_val("ready_port", 32'(req_ready), 32'(2'b01 << p));
        check_val("latency", 32'(k), 32'(due));
        w = ref_apply(we[p], a[p], d[p], s[p]);
        if (!we[p]) rdata_m = w;
        check_val("rdata", req_rdata, rdata_m);
        grant_m = p[0];
        check_val("grant", 32'(grant), 32'(grant_m));
        $display("txn port=%0d we=%0b addr=%05h wdata=%08h wstrb=%h rdata=%08h cycles=%0d",
                 p, we[p], a[p], d[p], s[p], req_rdata, k);
        req_valid[p] = 1'b0;
        served++;
        if (served < n) due = k + 1 + exp_lat(we[order[1]], s[order[1]]);
      end
    end
    if (served < n) check_val("timeout", 32'(served), 32'(n));
    req_valid = 2'b00;
    @(posedge clk); #1;
    check_val("oe_cycles", 32'(oe_cnt - oe0), 32'(oe_e));
    check_val("we_cycles", 32'(we_cnt - we0), 32'(we_e));
    check_val("cs_cycles", 32'(cs_cnt - cs0), 32'(cs_e));
  endtask

  initial begin
    logic [1:0]  m, w;
    logic [16:0] ra0, ra1;
    logic [31:0] rd0, rd1;
    logic [3:0]  rs0, rs1;
    logic [15:0] v, old_hi;
    resetn = 1'b0; req_valid = '0; req_we = '0; req_addr0 = '0; req_addr1 = '0;
    req_wdata0 = '0; req_wdata1 = '0; req_wstrb0 = '0; req_wstrb1 = '0;
    for (int i = 0; i < 64; i++) begin
      v = 16'($urandom);
      sram_mem[i] = v;
      ref_mem[i]  = v;
    end
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_cs_n", 32'(sram_cs_n), 32'd1);
    check_val("rst_oe_n", 32'(sram_oe_n), 32'd1);
    check_val("rst_we_n", 32'(sram_we_n), 32'd1);
    check_val("rst_d_oe", 32'(sram_d_oe), 32'd0);
    check_val("rst_addr", 32'(sram_addr), 32'd0);
    check_val("rst_d_out", 32'(sram_d_out), 32'd0);
    check_val("rst_ready", 32'(req_ready), 32'd0);
    check_val("rst_rdata", req_rdata, 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_grant", 32'(grant), 32'd1);
    resetn = 1'b1; grant_m = 1'b1; rdata_m = 32'd0;
    @(posedge clk); #1;

    // Contention from reset: port 0 first, then alternation on repeats.
    run_txns(2'b11, 2'b00, 17'd1, 17'd2, 32'd0, 32'd0, 4'h0, 4'h0);
    run_txns(2'b11, 2'b00, 17'd4, 17'd6, 32'd0, 32'd0, 4'h0, 4'h0);
    run_txns(2'b11, 2'b00, 17'd7, 17'd8, 32'd0, 32'd0, 4'h0, 4'h0);

    sram_mem[0] = 16'h5678; ref_mem[0] = 16'h5678;
    sram_mem[1] = 16'h1234; ref_mem[1] = 16'h1234;
    run_txns(2'b10, 2'b00, 17'd0, 17'd0, 32'd0, 32'd0, 4'h0, 4'h0);
    check_val("t1_rdata", req_rdata, 32'h1234_5678);

    run_txns(2'b01, 2'b01, 17'd3, 17'd0, 32'hCAFE_BABE, 32'd0, 4'hF, 4'h0);
    check_val("t2_lo", 32'(sram_mem[6]), 32'h0000_BABE);
    check_val("t2_hi", 32'(sram_mem[7]), 32'h0000_CAFE);

    run_txns(2'b10, 2'b10, 17'd0, 17'd3, 32'd0, 32'h0000_00AA, 4'h0, 4'h1);
    check_val("t3_lo", 32'(sram_mem[6]), 32'h0000_BAAA);
    check_val("t3_hi", 32'(sram_mem[7]), 32'h0000_CAFE);

    run_txns(2'b01, 2'b01, 17'd5, 17'd0, 32'h1357_9BDF, 32'd0, 4'h0, 4'h0);

    for (int it = 0; it < 40; it++) begin
      m   = 2'($urandom_range(1, 3));
      w   = 2'($urandom_range(0, 3));
      ra0 = 17'($urandom_range(0, 15));
      ra1 = 17'($urandom_range(0, 15));
      rd0 = $urandom;
      rd1 = $urandom;
      rs0 = 4'($urandom_range(0, 15));
      rs1 = 4'($urandom_range(0, 15));
      run_txns(m, w, ra0, ra1, rd0, rd1, rs0, rs1);
    end

    // Reset during the high-half write window of a port-0 full write to word 9.
    old_hi = ref_mem[19];
    req_we = 2'b01; req_addr0 = 17'd9; req_wdata0 = 32'h1111_2222; req_wstrb0 = 4'hF;
    req_valid = 2'b01;
    repeat (4) @(posedge clk);
    #1;
    check_val("mid_we_low", 32'(sram_we_n), 32'd0);
    check_val("mid_addr", 32'(sram_addr), 32'd19);
    #1 resetn = 1'b0;
    #1;
    check_val("arst_cs_n", 32'(sram_cs_n), 32'd1);
    check_val("arst_oe_n", 32'(sram_oe_n), 32'd1);
    check_val("arst_we_n", 32'(sram_we_n), 32'd1);
    check_val("arst_d_oe", 32'(sram_d_oe), 32'd0);
    check_val("arst_busy", 32'(busy), 32'd0);
    check_val("arst_ready", 32'(req_ready), 32'd0);
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    grant_m = 1'b1; rdata_m = 32'd0;
    ref_mem[18] = 16'h2222;
    check_val("arst_lo_written", 32'(sram_mem[18]), 32'h0000_2222);
    check_val("arst_hi_kept", 32'(sram_mem[19]), 32'(old_hi));
    check_val("arst_grant", 32'(grant), 32'd1);
    @(posedge clk); #1;
    run_txns(2'b01, 2'b00, 17'd9, 17'd0, 32'd0, 32'd0, 4'h0, 4'h0);

    for (int i = 0; i < 64; i++) check_val("mem", 32'(sram_mem[i]), 32'(ref_mem[i]));
    check_val("protocol", 32'(viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
